// File: rtl/tdm_pkg.sv
// Shared types and constants for the 4-lane TDM demultiplexer.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef logic [SLOT_W-1:0] slot_t;

  // Frame-lock state; LOCKED drives the locked output directly.
  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_slot_ctr.sv
// Wrapping slot counter: tracks which lane the next valid beat lands in.
module tdm_slot_ctr
  import tdm_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  adv,
  input  logic  load1,
  output slot_t slot,
  output logic  last
);

  slot_t slot_q;
  slot_t slot_d;

  // Next slot: load1 wins (frame restarts after slot 0), otherwise advance on a beat.
  always_comb begin
    slot_d = slot_q;
    if (load1) begin
      slot_d = slot_t'(1);
    end else if (adv) begin
      slot_d = slot_q + slot_t'(1);
    end
  end

  // Slot register with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == slot_t'(NUM_SLOTS - 1));

endmodule

// File: rtl/tdm_demux4.sv
// Frame-locking time-division demultiplexer: one serial bit per valid beat,
// steered into 4 lanes and presented in parallel once per complete frame.
//
// Handshake: din_valid is a qualifier only (no ready). A beat is consumed on
// every rising edge where din_valid=1; frame_sync is meaningful only then.
// With din_valid=0 all state holds and the pulse outputs return to 0.
module tdm_demux4
  import tdm_pkg::*;
#(
  parameter int ERR_MAX = 3,
  parameter int ERR_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_sync,
  output logic [3:0] q,
  output logic [1:0] sel,
  output logic       frame_valid,
  output logic       locked,
  output logic       sync_err
);

  state_e           state_q, state_d;
  logic [2:0]       shadow_q, shadow_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [ERR_W-1:0] err_inc;
  logic [3:0]       q_q, q_d;
  logic             frame_valid_q, frame_valid_d;
  logic             sync_err_q, sync_err_d;

  logic  ctr_adv, ctr_load1, ctr_clr, ctr_rst_n;
  slot_t slot;
  logic  slot_last;

  // Lock loss returns the slot counter to 0 through its synchronous clear.
  assign ctr_rst_n = rst_n & ~ctr_clr;

  tdm_slot_ctr u_slot_ctr (
    .clk   (clk),
    .rst_n (ctr_rst_n),
    .adv   (ctr_adv),
    .load1 (ctr_load1),
    .slot  (slot),
    .last  (slot_last)
  );

  assign err_inc = err_cnt_q + ERR_W'(1);

  // Frame-lock FSM, shadow capture, error counting and output update.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    err_cnt_d     = err_cnt_q;
    q_d           = q_q;
    frame_valid_d = 1'b0;
    sync_err_d    = 1'b0;
    ctr_adv       = 1'b0;
    ctr_load1     = 1'b0;
    ctr_clr       = 1'b0;

    if (din_valid) begin
      case (state_q)
        HUNT: begin
          if (frame_sync) begin
            shadow_d  = {2'b00, din};
            ctr_load1 = 1'b1;
            err_cnt_d = '0;
            state_d   = LOCKED;
          end
        end
        LOCKED: begin
          if (slot == '0 && frame_sync) begin
            // Aligned start of frame.
            err_cnt_d   = '0;
            shadow_d[0] = din;
            ctr_adv     = 1'b1;
          end else if (slot == '0 || frame_sync) begin
            sync_err_d = 1'b1;
            if (err_inc >= ERR_W'(ERR_MAX)) begin
              // Too many consecutive errors: drop lock, no capture.
              state_d   = HUNT;
              err_cnt_d = '0;
              ctr_clr   = 1'b1;
            end else begin
              err_cnt_d = err_inc;
              if (frame_sync) begin
                // Misplaced sync: abandon partial frame, restart at slot 0.
                shadow_d  = {2'b00, din};
                ctr_load1 = 1'b1;
              end else begin
                // Missing sync: keep the bit as slot 0 without realigning.
                shadow_d[0] = din;
                ctr_adv     = 1'b1;
              end
            end
          end else begin
            if (slot_last) begin
              q_d           = {din, shadow_q};
              frame_valid_d = 1'b1;
            end else begin
              shadow_d[slot] = din;
            end
            ctr_adv = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= HUNT;
      shadow_q      <= '0;
      err_cnt_q     <= '0;
      q_q           <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      err_cnt_q     <= err_cnt_d;
      q_q           <= q_d;
      frame_valid_q <= frame_valid_d;
      sync_err_q    <= sync_err_d;
    end
  end

  assign q           = q_q;
  assign sel         = slot;
  assign frame_valid = frame_valid_q;
  assign locked      = (state_q == LOCKED);
  assign sync_err    = sync_err_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed scenarios plus a randomized run, all
// checked against a frame-level reference model kept in this file.
module tb_tdm_demux4;

  localparam int ERR_MAX = 3;
  localparam int ERR_W   = 4;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_sync;
  logic [3:0] q;
  logic [1:0] sel;
  logic       frame_valid;
  logic       locked;
  logic       sync_err;

  int n_cmp;
  int n_fail;

  // Reference model state.
  bit         m_lock;
  int         m_slot;
  int         m_err;
  logic [3:0] m_buf;
  logic [3:0] m_q;
  bit         m_fv;
  bit         m_se;

  tdm_demux4 #(.ERR_MAX(ERR_MAX), .ERR_W(ERR_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .din_valid   (din_valid),
    .frame_sync  (frame_sync),
    .q           (q),
    .sel         (sel),
    .frame_valid (frame_valid),
    .locked      (locked),
    .sync_err    (sync_err)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model of one clock edge.
  task automatic model_step(input bit r, input bit v, input bit d, input bit fs);
    m_fv = 0;
    m_se = 0;
    if (!r) begin
      m_lock = 0; m_slot = 0; m_err = 0; m_buf = '0; m_q = '0;
    end else if (v) begin
      if (!m_lock) begin
        if (fs) begin
          m_buf = '0; m_buf[0] = d; m_slot = 1; m_err = 0; m_lock = 1;
        end
      end else if (m_slot == 0 && fs) begin
        m_err = 0; m_buf[0] = d; m_slot = 1;
      end else if (m_slot == 0 || fs) begin
        m_se = 1;
        m_err = m_err + 1;
        if (m_err >= ERR_MAX) begin
          m_lock = 0; m_slot = 0; m_err = 0;
        end else if (fs) begin
          m_buf = '0; m_buf[0] = d; m_slot = 1;
        end else begin
          m_buf[0] = d; m_slot = 1;
        end
      end else begin
        m_buf[m_slot] = d;
        if (m_slot == 3) begin
          m_q = m_buf; m_fv = 1; m_slot = 0;
        end else begin
          m_slot = m_slot + 1;
        end
      end
    end
  endtask

  // Driver: apply inputs for one cycle, update model, settle past the edge.
  task automatic cyc(input bit r, input bit v, input bit d, input bit fs);
    rst_n = r; din_valid = v; din = d; frame_sync = fs;
    @(posedge clk);
    model_step(r, v, d, fs);
    #1;
  endtask

  task automatic beat(input bit d, input bit fs);
    cyc(1'b1, 1'b1, d, fs);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, $urandom_range(0, 1), $urandom_range(0, 1));
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (q !== 4'b0000) begin n_fail++; $display("FAIL reset_q got %b want 0000", q); end
    n_cmp++; if (sel !== 2'd0) begin n_fail++; $display("FAIL reset_sel got %0d want 0", sel); end
    n_cmp++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (frame_valid !== 1'b0 || sync_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_pulses got fv=%b se=%b want 0 0", frame_valid, sync_err);
    end
  endtask

  task automatic test_lock();
    do_reset();
    beat(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b1 || sel !== 2'd1) begin
      n_fail++; $display("FAIL lock_first got locked=%b sel=%0d want 1 1", locked, sel);
    end
    beat(1'b0, 1'b0);
    beat(1'b1, 1'b0);
    n_cmp++; if (q !== 4'b0000 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_early got q=%b fv=%b want 0000 0", q, frame_valid);
    end
    beat(1'b1, 1'b0);
    n_cmp++; if (q !== 4'b1101 || frame_valid !== 1'b1) begin
      n_fail++; $display("FAIL lock_frame got q=%b fv=%b want 1101 1", q, frame_valid);
    end
    idle();
    n_cmp++; if (q !== 4'b1101 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL lock_hold got q=%b fv=%b want 1101 0", q, frame_valid);
    end
  endtask

  task automatic test_hunt();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat($urandom_range(0, 1), 1'b0);
      n_cmp++; if (locked !== 1'b0 || sel !== 2'd0 || frame_valid !== 1'b0 || q !== 4'b0000) begin
        n_fail++; $display("FAIL hunt_ignore beat %0d got locked=%b sel=%0d fv=%b q=%b want 0 0 0 0000",
                           i, locked, sel, frame_valid, q);
      end
    end
  endtask

  task automatic test_gapped();
    logic [3:0] bits;
    int fv_cnt;
    bits = 4'b0110;
    fv_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      beat(bits[i], i == 0);
      if (frame_valid === 1'b1) fv_cnt++;
      for (int g = 0; g < 3; g++) begin
        idle();
        if (frame_valid === 1'b1) fv_cnt++;
        n_cmp++; if (sel !== 2'((i + 1) % 4)) begin
          n_fail++; $display("FAIL gap_sel got %0d want %0d", sel, (i + 1) % 4);
        end
      end
    end
    n_cmp++; if (fv_cnt !== 1) begin n_fail++; $display("FAIL gap_fv_count got %0d want 1", fv_cnt); end
    n_cmp++; if (q !== 4'b0110) begin n_fail++; $display("FAIL gap_q got %b want 0110", q); end
  endtask

  task automatic test_realign();
    bit rb;
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) beat($urandom_range(0, 1), i == 0);
    beat($urandom_range(0, 1), 1'b1);
    rb = $urandom_range(0, 1);
    beat(rb, 1'b1);
    n_cmp++; if (sync_err !== 1'b1 || frame_valid !== 1'b0 || sel !== 2'd1) begin
      n_fail++; $display("FAIL realign_err got se=%b fv=%b sel=%0d want 1 0 1", sync_err, frame_valid, sel);
    end
    exp = {3'b000, rb};
    for (int i = 1; i < 4; i++) begin
      exp[i] = $urandom_range(0, 1);
      beat(exp[i], 1'b0);
      if (i < 3) begin
        n_cmp++; if (frame_valid !== 1'b0) begin
          n_fail++; $display("FAIL realign_abort got fv=%b want 0", frame_valid);
        end
      end
    end
    n_cmp++; if (frame_valid !== 1'b1 || q !== exp) begin
      n_fail++; $display("FAIL realign_frame got fv=%b q=%b want 1 %b", frame_valid, q, exp);
    end
  endtask

  task automatic test_lock_loss();
    int se_cnt;
    se_cnt = 0;
    do_reset();
    for (int i = 0; i < 4; i++) beat($urandom_range(0, 1), i == 0);
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) begin
        beat($urandom_range(0, 1), 1'b0);
        if (sync_err === 1'b1) se_cnt++;
        if (f == 2 && i == 0) begin
          n_cmp++; if (locked !== 1'b0 || sel !== 2'd0) begin
            n_fail++; $display("FAIL loss_drop got locked=%b sel=%0d want 0 0", locked, sel);
          end
        end
      end
    end
    n_cmp++; if (se_cnt !== 3) begin n_fail++; $display("FAIL loss_err_count got %0d want 3", se_cnt); end
    n_cmp++; if (locked !== 1'b0 || sel !== 2'd0) begin
      n_fail++; $display("FAIL loss_hunt got locked=%b sel=%0d want 0 0", locked, sel);
    end
    beat(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b1 || sel !== 2'd1) begin
      n_fail++; $display("FAIL loss_relock got locked=%b sel=%0d want 1 1", locked, sel);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) beat(1'b1, i == 0);
    beat(1'b1, 1'b1);
    beat(1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (q !== 4'b0000 || sel !== 2'd0 || locked !== 1'b0 || frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset got q=%b sel=%0d locked=%b fv=%b want 0000 0 0 0", q, sel, locked, frame_valid);
    end
    for (int i = 0; i < 4; i++) beat(1'b1, 1'b0);
    n_cmp++; if (locked !== 1'b0 || sel !== 2'd0 || q !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_ignore got locked=%b sel=%0d q=%b want 0 0 0000", locked, sel, q);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bits;
    int fv_cnt;
    fv_cnt = 0;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      bits = 4'($urandom);
      for (int i = 0; i < 4; i++) begin
        beat(bits[i], i == 0);
        if (frame_valid === 1'b1) fv_cnt++;
      end
      n_cmp++; if (frame_valid !== 1'b1 || q !== bits) begin
        n_fail++; $display("FAIL b2b_frame %0d got fv=%b q=%b want 1 %b", f, frame_valid, q, bits);
      end
    end
    n_cmp++; if (fv_cnt !== 3) begin n_fail++; $display("FAIL b2b_fv_count got %0d want 3", fv_cnt); end
  endtask

  task automatic test_random();
    bit r, v, d, fs;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) != 0);
      v  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      fs = (m_slot == 0) ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 19) == 0);
      cyc(r, v, d, fs);
      n_cmp++; if (q !== m_q || sel !== 2'(m_slot) || locked !== m_lock ||
                   frame_valid !== m_fv || sync_err !== m_se) begin
        n_fail++;
        $display("FAIL random cyc %0d got q=%b sel=%0d lk=%b fv=%b se=%b want q=%b sel=%0d lk=%b fv=%b se=%b",
                 i, q, sel, locked, frame_valid, sync_err, m_q, m_slot, m_lock, m_fv, m_se);
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; din = 1'b0; din_valid = 1'b0; frame_sync = 1'b0;
    m_lock = 0; m_slot = 0; m_err = 0; m_buf = '0; m_q = '0; m_fv = 0; m_se = 0;
    test_reset();
    test_lock();
    test_hunt();
    test_gapped();
    test_realign();
    test_lock_loss();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
